// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if: register bus between the decoder and the input filter.
interface gpio_in_filter_if;
    logic        sel;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output sel, wr_en, rd_en, addr, wdata, input rdata);
    modport slave (input sel, wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: synchronize, debounce and edge-detect pad inputs with a small irq register set.
module gpio_in_filter #(
    parameter int WIDTH   = 32,
    parameter int DEB_DIV = 1000
) (
    input  logic             clk,
    input  logic             resetn,
    gpio_in_filter_if.slave  bus,
    input  logic [WIDTH-1:0] gpio_raw,
    output logic [WIDTH-1:0] gpio_clean,
    output logic             irq
);
    localparam int PW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEB_DIV - 1);
    logic [PW-1:0] pre;
    logic tick, wr, rd;
    logic [WIDTH-1:0] s1, s2, irq_en, status, edge_sel, flip, set, wr_data;
    logic [WIDTH-1:0][1:0] cnt;
    logic [31:0] rd_val;
    assign tick = pre == LAST;
    assign wr = bus.sel && bus.wr_en;
    assign rd = bus.sel && bus.rd_en;
    assign wr_data = bus.wdata[WIDTH-1:0];
    assign set = flip & ~(s2 ^ edge_sel);
    assign irq = |(status & irq_en);
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++)
            flip[i] = tick && (s2[i] != gpio_clean[i]) && (cnt[i] == 2'd2);
    end
    always_comb
        rd_val = bus.addr == 2'd0 ? 32'(gpio_clean) :
                 bus.addr == 2'd1 ? 32'(irq_en) :
                 bus.addr == 2'd2 ? 32'(status) : 32'(edge_sel);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1         <= '0;
            s2         <= '0;
            pre        <= '0;
            cnt        <= '0;
            gpio_clean <= '0;
        end else begin
            s1         <= gpio_raw;
            s2         <= s1;
            pre        <= tick ? '0 : pre + 1'b1;
            gpio_clean <= gpio_clean ^ flip;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= !tick ? cnt[i] :
                          (s2[i] == gpio_clean[i] || flip[i]) ? 2'd0 : cnt[i] + 2'd1;
        end
    end
    // a set event in the same cycle as its W1C wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en    <= '0;
            status    <= '0;
            edge_sel  <= '0;
            bus.rdata <= '0;
        end else begin
            irq_en    <= (wr && bus.addr == 2'd1) ? wr_data : irq_en;
            edge_sel  <= (wr && bus.addr == 2'd3) ? wr_data : edge_sel;
            status    <= (status & ~((wr && bus.addr == 2'd2) ? wr_data : '0)) | set;
            bus.rdata <= rd ? rd_val : bus.rdata;
        end
    end
endmodule
